// File: rtl/hazard_forward_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and the hazard/forwarding controller.
interface hazard_forward_ctrl_if;
  logic [31:0] ir2_output;
  logic [31:0] ir3_output;
  logic        branch_control_input;
  logic [1:0]  select_operand1;
  logic [1:0]  select_operand2;
  logic [1:0]  select_md4;
  logic        stall_pc;
  logic        bubble_ir3;
  logic        flush_ir2;
  logic [31:0] stall_count;
  logic [31:0] flush_count;
  logic        flush_state;

  // Timing contract (no valid/ready pairs): ir2/ir3/branch are sampled every rising edge;
  // stall_pc/bubble_ir3/flush_ir2 answer in the same cycle and the datapath must obey them
  // at that edge; the selects are registered and describe the instruction now in execute.
  modport master (
    output ir2_output, ir3_output, branch_control_input,
    input  select_operand1, select_operand2, select_md4,
    input  stall_pc, bubble_ir3, flush_ir2,
    input  stall_count, flush_count, flush_state
  );

  modport slave (
    input  ir2_output, ir3_output, branch_control_input,
    output select_operand1, select_operand2, select_md4,
    output stall_pc, bubble_ir3, flush_ir2,
    output stall_count, flush_count, flush_state
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: registered forwarding selects, load-use stall, branch flush/bubble.
// Optional HAZARD_STATS_EN builds saturating stall/flush statistics counters.
module hazard_forward_ctrl #(
  parameter int          REG_W     = 5,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_ctrl_if.slave bus
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } dst_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state;
  dst_t             dst3, dst4, dec2;
  logic [6:0]       opc2;
  logic [REG_W-1:0] rs1, rs2;
  logic             use_rs1, use_rs2, is_store;
  logic             load_use, branch_taken, bubble_now, stall_now;
  logic [1:0]       sel1_q, sel2_q, selmd_q;

  assign opc2     = bus.ir2_output[6:0];
  assign rs1      = bus.ir2_output[15 +: REG_W];
  assign rs2      = bus.ir2_output[20 +: REG_W];
  assign use_rs1  = !(opc2 inside {OP_LUI, OP_AUI, OP_JAL});
  assign use_rs2  = opc2 inside {OP_R, OP_ST, OP_BR};
  assign is_store = (opc2 == OP_ST);

  // The flush NOP never registers as a producer, whatever its encoding.
  assign dec2.rd      = bus.ir2_output[7 +: REG_W];
  assign dec2.is_load = (opc2 == OP_LD);
  assign dec2.valid   = (opc2 inside {OP_R, OP_I, OP_LD, OP_LUI, OP_AUI, OP_JAL, OP_JALR}) &&
                        (dec2.rd != '0) && (bus.ir2_output != NOP_INSTR);

  // Youngest producer first: a non-load in execute forwards from z4, memory stage from z5.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] rs,
                                         input dst_t d3, input dst_t d4);
    if (!used || rs == '0) return 2'd0;
    if (d3.valid && d3.rd == rs && !d3.is_load) return 2'd2;
    if (d4.valid && d4.rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  assign load_use = (state == RUN) && dst3.valid && dst3.is_load &&
                    ((use_rs1 && rs1 == dst3.rd) || (use_rs2 && rs2 == dst3.rd));
  assign branch_taken = (state == RUN) && bus.branch_control_input &&
                        (bus.ir3_output[6:0] == OP_BR);
  assign bubble_now   = branch_taken || load_use;
  assign stall_now    = load_use && !branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      dst3    <= '0;
      dst4    <= '0;
      sel1_q  <= 2'd0;
      sel2_q  <= 2'd0;
      selmd_q <= 2'd0;
    end else begin
      dst4 <= dst3;
      if (bubble_now) begin
        dst3    <= '0;
        sel1_q  <= 2'd0;
        sel2_q  <= 2'd0;
        selmd_q <= 2'd0;
      end else begin
        dst3    <= dec2;
        sel1_q  <= fwd_sel(use_rs1, rs1, dst3, dst4);
        sel2_q  <= fwd_sel(use_rs2 && !is_store, rs2, dst3, dst4);
        selmd_q <= fwd_sel(is_store, rs2, dst3, dst4);
      end
      case (state)
        RUN:     if (branch_taken) state <= FLUSH;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Gated by reset so nothing leaks out while reset is held.
  assign bus.stall_pc        = reset && stall_now;
  assign bus.bubble_ir3      = reset && bubble_now;
  assign bus.flush_ir2       = reset && branch_taken;
  assign bus.select_operand1 = sel1_q;
  assign bus.select_operand2 = sel2_q;
  assign bus.select_md4      = selmd_q;
  assign bus.flush_state     = (state == FLUSH);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_now && stall_cnt_q != 32'hFFFFFFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_taken && flush_cnt_q != 32'hFFFFFFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  assign bus.stall_count = 32'h0;
  assign bus.flush_count = 32'h0;
`endif
endmodule
